// File: rtl/sram_mac_lanes.sv
// Multi-lane weight-stationary MAC: per-lane weight SRAM, broadcast activation.
// Two-stage pipeline (SRAM read, multiply/accumulate) behind an IDLE/INIT/RUN FSM.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   pe_ce             clock enable; low freezes all state, valid_out forced low
//   init_enable       request weight (re)load
//   stop              leave RUN for IDLE
//   mode              0 = per-sample product, 1 = sum over DEPTH samples
//   in_valid          qualifies wdata_in (INIT) or act_in (RUN)
//   wdata_in          one weight per lane, lane 0 in LSBs
//   act_in            activation broadcast to all lanes
//   data_out          per-lane result, zero-extended, lane 0 in LSBs
//   valid_out         one-cycle pulse per result
//   init_done         high while in RUN
//   busy              high when not IDLE or pipeline holds a sample
module sram_mac_lanes #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int LANES      = 4,
   localparam int AW        = $clog2(DEPTH),
   localparam int ACC_WIDTH = 2*DATA_WIDTH+AW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pe_ce,
   input  logic                         init_enable,
   input  logic                         stop,
   input  logic                         mode,
   input  logic                         in_valid,
   input  logic [LANES*DATA_WIDTH-1:0]  wdata_in,
   input  logic [DATA_WIDTH-1:0]        act_in,
   output logic [LANES*ACC_WIDTH-1:0]   data_out,
   output logic                         valid_out,
   output logic                         init_done,
   output logic                         busy
);

   localparam int PW = 2*DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t          state;
   logic [AW-1:0]   addr_ptr;
   logic            loaded;
   logic            run_mode;

   logic            at_last;
   logic            wr_en;
   logic            accept;
   logic            flush;
   logic            run_entry;

   // Stage 1: registered SRAM read plus sample side-band
   logic [LANES-1:0][DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0]            act_q;
   logic                             s1_vld;
   logic                             s1_last;
   logic                             s1_mode;

   // Stage 2: products, accumulators, output register
   logic [LANES-1:0][PW-1:0]         prod;
   logic [LANES-1:0][ACC_WIDTH-1:0]  sum;
   logic [LANES-1:0][ACC_WIDTH-1:0]  acc;
   logic [LANES-1:0][ACC_WIDTH-1:0]  dout_q;
   logic                             vld_q;

   assign at_last = (addr_ptr == AW'(DEPTH-1));

   assign wr_en = pe_ce && (state == INIT) && in_valid;

   // A transition cycle never accepts the sample presented with it
   assign accept = pe_ce && (state == RUN) && in_valid
                   && !init_enable && !stop;

   assign flush = pe_ce && (state == RUN) && init_enable;

   assign run_entry =
      (wr_en && at_last) ||
      (pe_ce && (state == IDLE) && !init_enable
       && in_valid && loaded);

   // ------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_ptr <= '0;
         loaded   <= 1'b0;
         run_mode <= 1'b0;
      end else if (pe_ce) begin
         case (state)
            IDLE: begin
               if (init_enable) begin
                  state    <= INIT;
                  addr_ptr <= '0;
               end else if (in_valid && loaded) begin
                  state    <= RUN;
                  addr_ptr <= '0;
                  run_mode <= mode;
               end
            end
            INIT: begin
               if (in_valid) begin
                  if (at_last) begin
                     state    <= RUN;
                     addr_ptr <= '0;
                     loaded   <= 1'b1;
                     run_mode <= mode;
                  end else begin
                     addr_ptr <= addr_ptr + AW'(1);
                  end
               end
            end
            RUN: begin
               if (init_enable) begin
                  state    <= INIT;
                  addr_ptr <= '0;
                  loaded   <= 1'b0;
               end else if (stop) begin
                  state    <= IDLE;
               end else if (in_valid) begin
                  addr_ptr <= addr_ptr + AW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               addr_ptr <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------
   // Weight storage: one single-port RAM per lane, no reset
   // ------------------------------------------------------------
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (wr_en)
            mem[addr_ptr] <= wdata_in[k*DATA_WIDTH +: DATA_WIDTH];
         if (accept)
            rd_q[k] <= mem[addr_ptr];
      end

      always_comb begin
         prod[k] = PW'(rd_q[k]) * PW'(act_q);
         sum[k]  = acc[k] + ACC_WIDTH'(prod[k]);
      end
   end

   // ------------------------------------------------------------
   // Stage 1 side-band
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_mode <= 1'b0;
         act_q   <= '0;
      end else if (pe_ce) begin
         s1_vld <= accept;
         if (accept) begin
            act_q   <= act_in;
            s1_last <= at_last;
            s1_mode <= run_mode;
         end
      end
   end

   // ------------------------------------------------------------
   // Stage 2: multiply / accumulate / output
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else if (pe_ce) begin
         vld_q <= 1'b0;
         if (flush) begin
            // Reload request drops the sample sitting in stage 1
            acc <= '0;
         end else if (run_entry) begin
            acc <= '0;
         end else if (s1_vld) begin
            vld_q <= !s1_mode || s1_last;
            for (int k = 0; k < LANES; k++) begin
               if (!s1_mode) begin
                  dout_q[k] <= ACC_WIDTH'(prod[k]);
               end else if (s1_last) begin
                  // Emit full sum; next sample starts from zero
                  dout_q[k] <= sum[k];
                  acc[k]    <= '0;
               end else begin
                  acc[k]    <= sum[k];
               end
            end
         end
      end
   end

   assign data_out  = dout_q;
   assign valid_out = vld_q && pe_ce;
   assign init_done = (state == RUN);
   assign busy      = (state != IDLE) || s1_vld || vld_q;

endmodule

// File: tb/tb_sram_mac_lanes.sv
// Directed self-checking bench for sram_mac_lanes (default parameters).
// Steps advance one clock; outputs are sampled 1ns after the rising edge.
module tb_sram_mac_lanes;

   localparam int DW  = 8;
   localparam int ACC = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pe_ce = 1'b1;
   logic          init_enable = 1'b0;
   logic          stop = 1'b0;
   logic          mode = 1'b0;
   logic          in_valid = 1'b0;
   logic [4*DW-1:0]  wdata_in = '0;
   logic [DW-1:0]    act_in = '0;
   logic [4*ACC-1:0] data_out;
   logic          valid_out;
   logic          init_done;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int acts [16];

   sram_mac_lanes dut (
      .clk         (clk),
      .rst         (rst),
      .pe_ce       (pe_ce),
      .init_enable (init_enable),
      .stop        (stop),
      .mode        (mode),
      .in_valid    (in_valid),
      .wdata_in    (wdata_in),
      .act_in      (act_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .init_done   (init_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [4*ACC-1:0] pk(int l0, int l1, int l2, int l3);
      return {ACC'(l3), ACC'(l2), ACC'(l1), ACC'(l0)};
   endfunction

   // Mode-0 result for weights w[k][a] = a+k
   function automatic logic [4*ACC-1:0] e0(int a, int x);
      return pk(a*x, (a+1)*x, (a+2)*x, (a+3)*x);
   endfunction

   initial begin
      // ---- reset ----
      step();
      chk("rst_data", data_out, '0);
      chk("rst_valid", valid_out, 0);
      chk("rst_done", init_done, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // ---- not loaded: in_valid in IDLE must not enter RUN ----
      in_valid = 1'b1;
      step();
      chk("idle_noload_done", init_done, 0);
      chk("idle_noload_busy", busy, 0);
      in_valid = 1'b0;

      // ---- load weights a+k, one idle gap mid-load ----
      init_enable = 1'b1;
      step();
      init_enable = 1'b0;
      chk("init_busy", busy, 1);
      for (int a = 0; a < 16; a++) begin
         if (a == 7) begin
            in_valid = 1'b0;
            step();
         end
         wdata_in = {DW'(a+3), DW'(a+2), DW'(a+1), DW'(a)};
         in_valid = 1'b1;
         step();
         if (a == 14) chk("load15_done", init_done, 0);
         if (a == 15) chk("load16_done", init_done, 1);
      end
      in_valid = 1'b0;

      // ---- mode 0, back-to-back stream over all addresses ----
      for (int i = 0; i < 16; i++)
         acts[i] = (i == 5) ? 3 : ((i*37 + 11) % 256);
      acts[15] = 255;
      for (int i = 0; i < 16; i++) begin
         act_in = DW'(acts[i]);
         in_valid = 1'b1;
         step();
         if (i > 0) begin
            chk("m0_valid", valid_out, 1);
            chk("m0_data", data_out, e0(i-1, acts[i-1]));
         end
         if (i == 6)
            chk("m0_lane2_a5", data_out[2*ACC +: ACC], 21);
      end
      in_valid = 1'b0;
      step();
      chk("m0_last_valid", valid_out, 1);
      chk("m0_last_data", data_out, e0(15, 255));
      step();
      chk("m0_drain_valid", valid_out, 0);
      chk("m0_hold_data", data_out, e0(15, 255));

      // ---- stall 3 cycles mid-stream ----
      act_in = 8'd10;
      in_valid = 1'b1;
      step();
      act_in = 8'd20;
      step();
      chk("st_a_valid", valid_out, 1);
      chk("st_a_data", data_out, e0(0, 10));
      pe_ce = 1'b0;
      act_in = 8'd99;
      repeat (3) begin
         step();
         chk("st_frz_valid", valid_out, 0);
         chk("st_frz_data", data_out, e0(0, 10));
         chk("st_frz_done", init_done, 1);
      end
      pe_ce = 1'b1;
      act_in = 8'd30;
      step();
      chk("st_b_valid", valid_out, 1);
      chk("st_b_data", data_out, e0(1, 20));
      in_valid = 1'b0;
      step();
      chk("st_c_valid", valid_out, 1);
      chk("st_c_data", data_out, e0(2, 30));
      step();
      chk("st_end_valid", valid_out, 0);

      // ---- mode 1 accumulate ----
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_done", init_done, 0);
      mode = 1'b1;
      in_valid = 1'b1;
      step();
      chk("m1_entry_done", init_done, 1);
      act_in = 8'd1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("m1_acc_quiet", valid_out, 0);
      end
      act_in = 8'd2;
      for (int j = 0; j < 16; j++) begin
         step();
         if (j == 0) begin
            chk("m1_sum1_valid", valid_out, 1);
            chk("m1_sum1_data", data_out, pk(120, 136, 152, 168));
         end else begin
            chk("m1_sum2_quiet", valid_out, 0);
         end
      end
      in_valid = 1'b0;
      step();
      chk("m1_sum2_valid", valid_out, 1);
      chk("m1_sum2_data", data_out, pk(240, 272, 304, 336));

      // ---- stop with a sample in flight ----
      stop = 1'b1;
      step();
      stop = 1'b0;
      mode = 1'b0;
      in_valid = 1'b1;
      step();
      act_in = 8'd5;
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      in_valid = 1'b0;
      chk("stop_fl_valid", valid_out, 1);
      chk("stop_fl_data", data_out, e0(0, 5));
      chk("stop_fl_done", init_done, 0);
      step();
      chk("stop_idle_valid", valid_out, 0);
      chk("stop_idle_busy", busy, 0);

      // ---- init_enable with a sample in flight ----
      in_valid = 1'b1;
      step();
      act_in = 8'd7;
      step();
      in_valid = 1'b0;
      init_enable = 1'b1;
      step();
      init_enable = 1'b0;
      chk("reinit_valid0", valid_out, 0);
      chk("reinit_done", init_done, 0);
      step();
      chk("reinit_valid1", valid_out, 0);
      chk("reinit_hold", data_out, e0(0, 5));

      // ---- reset mid-INIT ----
      wdata_in = {4{8'd255}};
      in_valid = 1'b1;
      repeat (5) step();
      rst = 1'b1;
      #1;
      chk("rstinit_data", data_out, '0);
      chk("rstinit_valid", valid_out, 0);
      chk("rstinit_done", init_done, 0);
      chk("rstinit_busy", busy, 0);
      rst = 1'b0;
      repeat (3) step();
      chk("post_rst_done", init_done, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", valid_out, 0);
      chk("post_rst_data", data_out, '0);

      // ---- full-scale weights ----
      in_valid = 1'b0;
      init_enable = 1'b1;
      step();
      init_enable = 1'b0;
      in_valid = 1'b1;
      repeat (16) step();
      chk("max_load_done", init_done, 1);
      act_in = 8'd255;
      step();
      in_valid = 1'b0;
      step();
      chk("max_valid", valid_out, 1);
      chk("max_data", data_out, pk(65025, 65025, 65025, 65025));

      // ---- reset mid-RUN ----
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstrun_data", data_out, '0);
      chk("rstrun_valid", valid_out, 0);
      rst = 1'b0;
      step();
      chk("rstrun_post0", valid_out, 0);
      step();
      chk("rstrun_post1", valid_out, 0);
      chk("rstrun_done", init_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
